// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - MIPS opcode/funct constants shared by the decode stage
package mips_defs;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  // Only the logical immediates zero-extend; LUI shifts its immediate and
  // the arithmetic immediates sign-extend.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - flop with synchronous reset, synchronous clear and enable
module flopenrc #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear beats enable so a flush squashes even a stalled stage.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ifid_decode.sv
// rtl/ifid_decode.sv - IF/ID pipeline register with instruction field decode
module ifid_decode #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic [DATA_W-1:0] instr_f,
  input  logic [DATA_W-1:0] pcplus4_f,
  input  logic              valid_f,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pcplus4_d,
  output logic              valid_d,
  output logic [5:0]        op_d,
  output logic [4:0]        rs_d,
  output logic [4:0]        rt_d,
  output logic [4:0]        rd_d,
  output logic [4:0]        shamt_d,
  output logic [5:0]        funct_d,
  output logic [15:0]       imm_d,
  output logic              is_imm_d,
  output logic              is_branch_d,
  output logic              is_jump_d
);

  import mips_defs::*;

  logic              load_en;
  logic [DATA_W-1:0] instr_load;
  logic [0:0]        valid_q;

  assign load_en    = ~stall_d;
  // A fetch bubble enters as a NOP so downstream never sees stale bits.
  assign instr_load = valid_f ? instr_f : NOP_INSTR[DATA_W-1:0];

  flopenrc #(.WIDTH(DATA_W), .RESET_VAL(NOP_INSTR[DATA_W-1:0])) u_instr (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush_d),
    .d   (instr_load),
    .q   (instr_d)
  );

  flopenrc #(.WIDTH(DATA_W), .RESET_VAL('0)) u_pcplus4 (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush_d),
    .d   (pcplus4_f),
    .q   (pcplus4_d)
  );

  flopenrc #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush_d),
    .d   (valid_f),
    .q   (valid_q)
  );

  assign valid_d = valid_q[0];

  always_comb begin
    op_d        = instr_d[31:26];
    rs_d        = instr_d[25:21];
    rt_d        = instr_d[20:16];
    rd_d        = instr_d[15:11];
    shamt_d     = instr_d[10:6];
    funct_d     = instr_d[5:0];
    imm_d       = instr_d[15:0];
    is_imm_d    = is_zext_op(instr_d[31:26]);
    is_branch_d = 1'b0;
    is_jump_d   = 1'b0;
    // Class flags feed the hazard unit, so bubbles must never raise them.
    if (valid_d) begin
      unique case (instr_d[31:26])
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: is_branch_d = 1'b1;
        OP_J, OP_JAL:                                is_jump_d   = 1'b1;
        OP_RTYPE: is_jump_d = (instr_d[5:0] == FN_JR) || (instr_d[5:0] == FN_JALR);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_decode.sv
// tb/tb_ifid_decode.sv - randomized scoreboard bench for ifid_decode
module tb_ifid_decode;

  logic        clk = 1'b0;
  logic        rst, stall_d, flush_d, valid_f;
  logic [31:0] instr_f, pcplus4_f;
  logic [31:0] instr_d, pcplus4_d;
  logic        valid_d, is_imm_d, is_branch_d, is_jump_d;
  logic [5:0]  op_d, funct_d;
  logic [4:0]  rs_d, rt_d, rd_d, shamt_d;
  logic [15:0] imm_d;

  always #5 clk = ~clk;

  ifid_decode dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .instr_f(instr_f), .pcplus4_f(pcplus4_f), .valid_f(valid_f),
    .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
    .funct_d(funct_d), .imm_d(imm_d), .is_imm_d(is_imm_d),
    .is_branch_d(is_branch_d), .is_jump_d(is_jump_d)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          done     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Applies the architectural IF/ID rules to the model, then queues the
  // state the register must hold after the coming edge.
  task automatic drive(input bit r, input bit s, input bit f,
                       input logic [31:0] ins, input logic [31:0] pc, input bit v);
    rst = r; stall_d = s; flush_d = f; instr_f = ins; pcplus4_f = pc; valid_f = v;
    if (r || f) begin
      m.instr = 32'h0; m.pc = 32'h0; m.valid = 1'b0;
    end else if (!s) begin
      m.instr = v ? ins : 32'h0;
      m.pc    = pc;
      m.valid = v;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                            6'h06, 6'h07, 6'h08, 6'h0C, 6'h0E, 6'h0F};
    logic [31:0] r = $urandom;
    if ($urandom_range(3) != 0) r[31:26] = ops[$urandom_range(11)];
    if (r[31:26] == 6'h00 && $urandom_range(1) == 1) r[5:0] = 6'h08 + 6'($urandom_range(1));
    return r;
  endfunction

  // Monitor: every cycle the register presents one state; compare it and
  // the decode derived arithmetically from the expected instruction word.
  initial begin
    exp_t e;
    int   op, fn;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e  = sb_q.pop_front();
        op = int'(e.instr >> 26);
        fn = int'(e.instr % 64);
        check("instr_d",   instr_d,   e.instr);
        check("pcplus4_d", pcplus4_d, e.pc);
        check("valid_d",   32'(valid_d), 32'(e.valid));
        check("op_d",      32'(op_d),    32'(op));
        check("rs_d",      32'(rs_d),    (e.instr >> 21) % 32);
        check("rt_d",      32'(rt_d),    (e.instr >> 16) % 32);
        check("rd_d",      32'(rd_d),    (e.instr >> 11) % 32);
        check("shamt_d",   32'(shamt_d), (e.instr >> 6) % 32);
        check("funct_d",   32'(funct_d), 32'(fn));
        check("imm_d",     32'(imm_d),   e.instr % 65536);
        check("is_imm_d",  32'(is_imm_d), 32'(op == 12 || op == 13 || op == 14));
        check("is_branch_d", 32'(is_branch_d),
              32'(e.valid && (op == 1 || (op >= 4 && op <= 7))));
        check("is_jump_d", 32'(is_jump_d),
              32'(e.valid && (op == 2 || op == 3 || (op == 0 && (fn == 8 || fn == 9)))));
      end
    end
  end

  initial begin
    m = '{32'h0, 32'h0, 1'b0};
    drive(1, 0, 0, 32'h3508_00FF, 32'h0, 1);
    drive(1, 0, 0, 32'h3508_00FF, 32'h0, 1);
    drive(0, 0, 0, 32'h3508_00FF, 32'h4, 1);
    drive(0, 0, 0, 32'h2108_FFFF, 32'h8, 1);
    drive(0, 0, 0, 32'h3C01_8000, 32'hC, 1);
    drive(0, 0, 0, 32'h1109_0003, 32'h10, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, rand_instr(), $urandom, 1);
    drive(0, 0, 0, 32'h0128_5020, 32'h14, 1);
    drive(0, 0, 0, 32'h03E0_0008, 32'h18, 1);
    drive(0, 1, 1, 32'h03E0_0008, 32'h18, 1);
    drive(0, 0, 0, 32'h0800_0010, 32'h40, 0);
    drive(0, 0, 0, 32'h0C00_0020, 32'h44, 1);
    drive(0, 1, 0, 32'h0000_F809, 32'h48, 1);
    drive(1, 1, 0, 32'h0000_F809, 32'h48, 1);
    drive(0, 0, 0, 32'h0000_F809, 32'h4C, 1);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(40) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
            rand_instr(), $urandom, $urandom_range(4) != 0);
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
